lms_adapt_ctrl: RTL and testbench
=================================

# lms_adapt_ctrl

Adaptation controller for the 3-tap LMS coefficient-update datapath. It builds the tap-delay line from the incoming sample stream and gates the error so coefficients move exactly once per valid sample. It schedules the step size (training, then tracking), supports freeze, and flags convergence. It sits between the sample/error sources and the LMS update block, driving that block's reset, step size, error and tap inputs.

## Interface
- NB_DATA, 32: data width, signed fixed point, all data ports
- NBF_DATA, 16: fractional bits (Q16.16)
- TRAIN_LEN, 1024: valid samples spent in TRAIN before TRACK
- CONV_CNT, 64: consecutive small-error samples required to declare convergence
- MU_TRAIN, 32'h0000_0200: step size in TRAIN (2^-7)
- MU_TRACK, 32'h0000_0020: step size in TRACK (2^-11)
- ERR_TH, 32'h0000_0100: convergence threshold on |error|
- DIV_TH, 32'h0040_0000: divergence threshold on |error| (64.0)
- i_clk  in  1  single clock, all logic rising-edge
- i_rst  in  1  one clock; reset is synchronous and active-low
- i_enable  in  1  adaptation run request; low forces IDLE
- i_freeze  in  1  hold coefficients while high
- i_valid  in  1  i_sample/i_error qualifier, one cycle per sample
- i_sample  in  NB_DATA  new input sample
- i_error  in  NB_DATA  error for the current sample
- o_x0, o_x1, o_x2  out  NB_DATA  tap-delay line (x0 newest)
- o_error  out  NB_DATA  gated error to the datapath
- o_mu  out  NB_DATA  current step size
- o_lms_rst  out  1  active-high reset to the LMS datapath
- o_state  out  2  IDLE=0, TRAIN=1, TRACK=2, FREEZE=3
- o_converged  out  1  convergence flag
- o_diverged  out  1  sticky divergence flag
- o_train_cnt  out  clog2(TRAIN_LEN+1)  training sample count

## Operation
- IDLE: o_lms_rst=1, o_mu=0, o_error=0, train count cleared. i_enable=1 moves to TRAIN.
- TRAIN: o_mu=MU_TRAIN. Each i_valid increments the count. The valid that makes count==TRAIN_LEN still uses MU_TRAIN, then moves to TRACK. The count saturates at TRAIN_LEN.
- TRACK: o_mu=MU_TRACK.
- FREEZE: entered from TRAIN/TRACK while i_freeze=1. The previous state is saved. o_error forced to 0 so taps hold; o_mu holds its value. i_freeze=0 returns to the saved state, and the count is preserved.
- Priority: i_enable=0 beats divergence, which beats freeze, which beats normal transitions. Any state goes to IDLE on i_enable=0.
- Delay line: on every i_valid in any state except IDLE, x2<=x1, x1<=x0, x0<=i_sample. The line clears in IDLE.
- Error gating: o_error=i_error for exactly the cycle after i_valid in TRAIN/TRACK, and 0 in every other cycle. The datapath updates every clock, so a zero error means hold.
- |error|: two's-complement absolute value. The most-negative code saturates to the maximum positive value.
- Convergence: in TRACK, each valid with |e|<ERR_TH increments a run counter; |e|>=ERR_TH clears it. At CONV_CNT, o_converged=1. The flag clears on a large error or on leaving TRACK, except that FREEZE holds it.

## Timing
- All outputs are registered. The i_valid sample at cycle t appears on o_x* and o_error at t+1. The coefficient update happens at t+2.
- o_lms_rst deasserts in the first TRAIN cycle, one cycle after i_enable is seen.
- Reset values: state IDLE, o_lms_rst=1, o_mu=0, o_x*=0, o_error=0, o_converged=0, o_diverged=0, o_train_cnt=0.
- i_rst low mid-operation: everything returns to reset values on the next edge. An in-flight update is dropped because o_error=0.
- i_valid coincident with i_freeze rising: the sample shifts into the delay line, but its error is gated to 0.

## Configuration
- LMS_CTRL_DIVERGENCE_EN defined: a valid with |e|>DIV_TH in TRAIN/TRACK causes the following:
  - o_lms_rst pulses for 1 cycle.
  - The train count and run count clear.
  - State goes to TRAIN.
  - o_error is 0 for that sample.
  - o_diverged is set and stays set until IDLE.
- Undefined: no divergence check, and o_diverged is tied to 0.

## Structure
- Shared package lms_pkg holds the state encoding constants, the default MU/threshold constants and the NB_DATA/NBF_DATA defaults.
- One sub-module, abs_sat, provides the saturating absolute value. It is instantiated once and shared by the convergence and divergence compares.

## Test plan
- Reset, then i_enable=1 at cycle 5: o_lms_rst=1 until the first TRAIN cycle, o_state=1, o_mu=0x200.
- 1024 valids in TRAIN: o_state=2 after the 1024th, and that sample's o_error is issued with o_mu=0x200; o_mu=0x20 afterwards.
- Samples 1,2,3 with i_valid: o_x0/x1/x2 = 3/2/1. o_error equals i_error only in the cycle after each valid and is 0 elsewhere.
- TRACK with 64 errors of 0x80: o_converged=1 after the 64th. One error of 0x100 clears it.
- i_freeze high mid-TRAIN at count 500 for 20 valids: o_error=0 throughout. On release, o_state=1 and the count resumes at 500.
- Macro on, error=0x0050_0000 in TRACK: 1-cycle o_lms_rst pulse, o_state=1, o_diverged=1. Then i_enable=0 leads to IDLE and o_diverged=0.

Source files
------------

// File: rtl/lms_adapt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lms_pkg
// Brief    : Shared state encoding and default constants for lms_adapt_ctrl.
// Revision : 1.0
// ============================================================================
package lms_pkg;

    localparam int          c_NB_DATA   = 32;
    localparam int          c_NBF_DATA  = 16;
    localparam int          c_TRAIN_LEN = 1024;
    localparam int          c_CONV_CNT  = 64;
    localparam logic [31:0] c_MU_TRAIN  = 32'h0000_0200;
    localparam logic [31:0] c_MU_TRACK  = 32'h0000_0020;
    localparam logic [31:0] c_ERR_TH    = 32'h0000_0100;
    localparam logic [31:0] c_DIV_TH    = 32'h0040_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_TRACK  = 2'd2,
        ST_FREEZE = 2'd3
    } lms_state_e;

    function automatic logic is_adapting(input lms_state_e s);
        return (s == ST_TRAIN) || (s == ST_TRACK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lms_adapt_ctrl_abs_sat.sv
`default_nettype none
// ============================================================================
// Module   : abs_sat
// Brief    : Two's-complement absolute value; the most-negative code maps to
//            the largest positive code instead of wrapping.
// Revision : 1.0
// ============================================================================
module abs_sat #(
    parameter int NB = 32
) (
    input  logic [NB-1:0] i_data,
    output logic [NB-1:0] o_abs
);

    localparam logic [NB-1:0] c_MIN = {1'b1, {(NB-1){1'b0}}};
    localparam logic [NB-1:0] c_MAX = {1'b0, {(NB-1){1'b1}}};
    localparam logic [NB-1:0] c_ONE = {{(NB-1){1'b0}}, 1'b1};

    always_comb begin
        o_abs = i_data;
        if (i_data == c_MIN) begin
            o_abs = c_MAX;
        end else if (i_data[NB-1]) begin
            o_abs = ~i_data + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lms_adapt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lms_adapt_ctrl
// Brief    : LMS adaptation controller: tap-delay line, error gating, step-size
//            schedule (TRAIN/TRACK), freeze and convergence detection.
//            Optional divergence recovery: define LMS_CTRL_DIVERGENCE_EN.
// Revision : 1.0
// ============================================================================
module lms_adapt_ctrl
    import lms_pkg::*;
#(
    parameter int                 NB_DATA   = c_NB_DATA,
    parameter int                 NBF_DATA  = c_NBF_DATA,
    parameter int                 TRAIN_LEN = c_TRAIN_LEN,
    parameter int                 CONV_CNT  = c_CONV_CNT,
    parameter logic [NB_DATA-1:0] MU_TRAIN  = NB_DATA'(c_MU_TRAIN),
    parameter logic [NB_DATA-1:0] MU_TRACK  = NB_DATA'(c_MU_TRACK),
    parameter logic [NB_DATA-1:0] ERR_TH    = NB_DATA'(c_ERR_TH),
    parameter logic [NB_DATA-1:0] DIV_TH    = NB_DATA'(c_DIV_TH)
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_enable,
    input  logic                               i_freeze,
    input  logic                               i_valid,
    input  logic [NB_DATA-1:0]                 i_sample,
    input  logic [NB_DATA-1:0]                 i_error,
    output logic [NB_DATA-1:0]                 o_x0,
    output logic [NB_DATA-1:0]                 o_x1,
    output logic [NB_DATA-1:0]                 o_x2,
    output logic [NB_DATA-1:0]                 o_error,
    output logic [NB_DATA-1:0]                 o_mu,
    output logic                               o_lms_rst,
    output logic [1:0]                         o_state,
    output logic                               o_converged,
    output logic                               o_diverged,
    output logic [$clog2(TRAIN_LEN+1)-1:0]     o_train_cnt
);

    localparam int               c_TCW        = $clog2(TRAIN_LEN + 1);
    localparam int               c_RCW        = $clog2(CONV_CNT + 1);
    localparam logic [c_TCW-1:0] c_TRAIN_LAST = c_TCW'(TRAIN_LEN - 1);
    localparam logic [c_TCW-1:0] c_TRAIN_MAX  = c_TCW'(TRAIN_LEN);
    localparam logic [c_TCW-1:0] c_TCNT_ONE   = c_TCW'(1);
    localparam logic [c_RCW-1:0] c_CONV_MAX   = c_RCW'(CONV_CNT);
    localparam logic [c_RCW-1:0] c_RCNT_ONE   = c_RCW'(1);

    if (NBF_DATA >= NB_DATA) begin : g_chk_nbf
        $error("NBF_DATA must be smaller than NB_DATA");
    end

    lms_state_e           r_state;
    lms_state_e           r_saved;
    lms_state_e           w_next;
    lms_state_e           w_saved_next;
    logic [NB_DATA-1:0]   r_x0, r_x1, r_x2;
    logic [NB_DATA-1:0]   r_error, w_error_next;
    logic [NB_DATA-1:0]   r_mu, w_mu_next;
    logic                 r_lms_rst, w_lms_rst_next;
    logic [c_TCW-1:0]     r_train_cnt, w_train_cnt_next;
    logic [c_RCW-1:0]     r_run_cnt, w_run_cnt_next, w_run_inc;
    logic                 r_conv, w_conv_next;
    logic                 r_div;
    logic [NB_DATA-1:0]   w_abs;
    logic                 w_small;
    logic                 w_active;
    logic                 w_train_done;
    logic                 w_upd;
    logic                 w_div_evt;
    logic                 w_line_clr;

    abs_sat #(
        .NB     (NB_DATA)
    ) u_abs_sat (
        .i_data (i_error),
        .o_abs  (w_abs)
    );

    assign w_small      = (w_abs < ERR_TH);
    assign w_active     = is_adapting(r_state);
    assign w_train_done = (r_state == ST_TRAIN) && i_valid && (r_train_cnt == c_TRAIN_LAST);
    assign w_run_inc    = (r_run_cnt == c_CONV_MAX) ? r_run_cnt : (r_run_cnt + c_RCNT_ONE);

`ifdef LMS_CTRL_DIVERGENCE_EN
    assign w_div_evt = i_enable && i_valid && w_active && (w_abs > DIV_TH);
`else
    logic w_div_th_unused;
    assign w_div_th_unused = ^DIV_TH;
    assign w_div_evt       = 1'b0;
`endif

    // Enable beats divergence, which beats freeze, which beats normal flow.
    always_comb begin
        w_next = r_state;
        if (!i_enable) begin
            w_next = ST_IDLE;
        end else if (w_div_evt) begin
            w_next = ST_TRAIN;
        end else begin
            case (r_state)
                ST_IDLE:   w_next = ST_TRAIN;
                ST_TRAIN: begin
                    if (i_freeze)          w_next = ST_FREEZE;
                    else if (w_train_done) w_next = ST_TRACK;
                end
                ST_TRACK:  if (i_freeze)  w_next = ST_FREEZE;
                ST_FREEZE: if (!i_freeze) w_next = r_saved;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_saved_next     = r_saved;
        w_upd            = 1'b0;
        w_error_next     = '0;
        w_mu_next        = r_mu;
        w_lms_rst_next   = 1'b0;
        w_train_cnt_next = r_train_cnt;
        w_run_cnt_next   = r_run_cnt;
        w_conv_next      = r_conv;
        w_line_clr       = (r_state == ST_IDLE) || (w_next == ST_IDLE);

        if ((w_next == ST_FREEZE) && (r_state != ST_FREEZE)) begin
            w_saved_next = r_state;
        end

        // A sample only reaches the datapath if adaptation continues past it.
        w_upd = i_valid && w_active && is_adapting(w_next) && !w_div_evt;
        if (w_upd) begin
            w_error_next = i_error;
        end

        case (w_next)
            ST_IDLE:   w_mu_next = '0;
            ST_TRAIN:  w_mu_next = MU_TRAIN;
            ST_TRACK:  w_mu_next = (r_state == ST_TRAIN) ? MU_TRAIN : MU_TRACK;
            default:   w_mu_next = r_mu;
        endcase

        w_lms_rst_next = (w_next == ST_IDLE) || w_div_evt;

        if ((w_next == ST_IDLE) || w_div_evt) begin
            w_train_cnt_next = '0;
        end else if (w_upd && (r_state == ST_TRAIN) && (r_train_cnt != c_TRAIN_MAX)) begin
            w_train_cnt_next = r_train_cnt + c_TCNT_ONE;
        end

        // Run count and flag survive FREEZE but nothing else outside TRACK.
        if (w_div_evt || ((w_next != ST_TRACK) && (w_next != ST_FREEZE))) begin
            w_run_cnt_next = '0;
            w_conv_next    = 1'b0;
        end else if (w_upd && (r_state == ST_TRACK)) begin
            if (w_small) begin
                w_run_cnt_next = w_run_inc;
                w_conv_next    = (w_run_inc == c_CONV_MAX);
            end else begin
                w_run_cnt_next = '0;
                w_conv_next    = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_saved     <= ST_TRAIN;
            r_x0        <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_error     <= '0;
            r_mu        <= '0;
            r_lms_rst   <= 1'b1;
            r_train_cnt <= '0;
            r_run_cnt   <= '0;
            r_conv      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_saved     <= w_saved_next;
            r_error     <= w_error_next;
            r_mu        <= w_mu_next;
            r_lms_rst   <= w_lms_rst_next;
            r_train_cnt <= w_train_cnt_next;
            r_run_cnt   <= w_run_cnt_next;
            r_conv      <= w_conv_next;
            if (w_line_clr) begin
                r_x0 <= '0;
                r_x1 <= '0;
                r_x2 <= '0;
            end else if (i_valid) begin
                r_x2 <= r_x1;
                r_x1 <= r_x0;
                r_x0 <= i_sample;
            end
        end
    end

`ifdef LMS_CTRL_DIVERGENCE_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_div <= 1'b0;
        end else if (w_next == ST_IDLE) begin
            r_div <= 1'b0;
        end else if (w_div_evt) begin
            r_div <= 1'b1;
        end
    end
`else
    assign r_div = 1'b0;
`endif

    assign o_x0        = r_x0;
    assign o_x1        = r_x1;
    assign o_x2        = r_x2;
    assign o_error     = r_error;
    assign o_mu        = r_mu;
    assign o_lms_rst   = r_lms_rst;
    assign o_state     = r_state;
    assign o_converged = r_conv;
    assign o_diverged  = r_div;
    assign o_train_cnt = r_train_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lms_adapt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lms_adapt_ctrl
// Brief    : Directed, table-driven self-checking bench for lms_adapt_ctrl.
// Revision : 1.0
// ============================================================================
module tb_lms_adapt_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_enable;
    logic        i_freeze;
    logic        i_valid;
    logic [31:0] i_sample;
    logic [31:0] i_error;
    logic [31:0] o_x0, o_x1, o_x2, o_error, o_mu;
    logic        o_lms_rst;
    logic [1:0]  o_state;
    logic        o_converged;
    logic        o_diverged;
    logic [10:0] o_train_cnt;

    int n_checks = 0;
    int n_errors = 0;

    lms_adapt_ctrl dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_enable    (i_enable),
        .i_freeze    (i_freeze),
        .i_valid     (i_valid),
        .i_sample    (i_sample),
        .i_error     (i_error),
        .o_x0        (o_x0),
        .o_x1        (o_x1),
        .o_x2        (o_x2),
        .o_error     (o_error),
        .o_mu        (o_mu),
        .o_lms_rst   (o_lms_rst),
        .o_state     (o_state),
        .o_converged (o_converged),
        .o_diverged  (o_diverged),
        .o_train_cnt (o_train_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        v;
        logic [31:0] s;
        logic [31:0] e;
        logic [31:0] x0;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] err;
        logic [10:0] cnt;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] s, input logic [31:0] e);
        i_valid  = 1'b1;
        i_sample = s;
        i_error  = e;
        tick();
        i_valid  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'd1,          32'h11,         32'd1,          32'd0, 32'd0, 32'h11,         11'd1};
        vecs[1] = '{1'b0, 32'd9,          32'h99,         32'd1,          32'd0, 32'd0, 32'h0,          11'd1};
        vecs[2] = '{1'b1, 32'd2,          32'h22,         32'd2,          32'd1, 32'd0, 32'h22,         11'd2};
        vecs[3] = '{1'b1, 32'd3,          32'h33,         32'd3,          32'd2, 32'd1, 32'h33,         11'd3};
        vecs[4] = '{1'b0, 32'd4,          32'h44,         32'd3,          32'd2, 32'd1, 32'h0,          11'd3};
        vecs[5] = '{1'b1, 32'hFFFF_FFFB,  32'hFFFF_FFF0,  32'hFFFF_FFFB,  32'd3, 32'd2, 32'hFFFF_FFF0,  11'd4};

        i_rst    = 1'b0;
        i_enable = 1'b0;
        i_freeze = 1'b0;
        i_valid  = 1'b0;
        i_sample = '0;
        i_error  = '0;

        repeat (3) tick();
        chk("rst_state",   32'(o_state),     32'd0);
        chk("rst_lms_rst", 32'(o_lms_rst),   32'd1);
        chk("rst_mu",      o_mu,             32'd0);
        chk("rst_x0",      o_x0,             32'd0);
        chk("rst_error",   o_error,          32'd0);
        chk("rst_conv",    32'(o_converged), 32'd0);
        chk("rst_div",     32'(o_diverged),  32'd0);
        chk("rst_cnt",     32'(o_train_cnt), 32'd0);

        i_rst = 1'b1;
        tick();
        tick();
        chk("idle_lms_rst", 32'(o_lms_rst), 32'd1);
        i_enable = 1'b1;
        tick();
        chk("train_state",   32'(o_state),   32'd1);
        chk("train_lms_rst", 32'(o_lms_rst), 32'd0);
        chk("train_mu",      o_mu,           32'h200);

        for (int i = 0; i < 6; i++) begin
            i_valid  = vecs[i].v;
            i_sample = vecs[i].s;
            i_error  = vecs[i].e;
            tick();
            i_valid  = 1'b0;
            chk($sformatf("vec%0d_x0", i),  o_x0,             vecs[i].x0);
            chk($sformatf("vec%0d_x1", i),  o_x1,             vecs[i].x1);
            chk($sformatf("vec%0d_x2", i),  o_x2,             vecs[i].x2);
            chk($sformatf("vec%0d_err", i), o_error,          vecs[i].err);
            chk($sformatf("vec%0d_cnt", i), 32'(o_train_cnt), 32'(vecs[i].cnt));
        end

        for (int i = 0; i < 496; i++) send(32'(i), 32'h10);
        chk("cnt_500", 32'(o_train_cnt), 32'd500);

        i_freeze = 1'b1;
        tick();
        chk("freeze_state", 32'(o_state), 32'd3);
        for (int i = 0; i < 20; i++) begin
            send(32'(i + 100), 32'h77);
            chk("freeze_err", o_error, 32'd0);
        end
        chk("freeze_cnt", 32'(o_train_cnt), 32'd500);
        chk("freeze_mu",  o_mu,             32'h200);
        chk("freeze_x0",  o_x0,             32'd119);
        i_freeze = 1'b0;
        tick();
        chk("unfreeze_state", 32'(o_state),     32'd1);
        chk("unfreeze_cnt",   32'(o_train_cnt), 32'd500);

        for (int i = 0; i < 523; i++) send(32'(i), 32'h10);
        chk("cnt_1023_state", 32'(o_state),     32'd1);
        chk("cnt_1023",       32'(o_train_cnt), 32'd1023);
        send(32'd5, 32'h99);
        chk("last_train_state", 32'(o_state),     32'd2);
        chk("last_train_err",   o_error,          32'h99);
        chk("last_train_mu",    o_mu,             32'h200);
        chk("last_train_cnt",   32'(o_train_cnt), 32'd1024);
        tick();
        chk("track_mu",  o_mu,             32'h20);
        chk("track_err", o_error,          32'd0);
        chk("track_cnt", 32'(o_train_cnt), 32'd1024);

        for (int i = 0; i < 63; i++) send(32'(i), 32'h80);
        chk("conv_63", 32'(o_converged), 32'd0);
        send(32'd1, 32'h80);
        chk("conv_64", 32'(o_converged), 32'd1);
        i_freeze = 1'b1;
        tick();
        chk("conv_frz_state", 32'(o_state),     32'd3);
        chk("conv_frz_hold",  32'(o_converged), 32'd1);
        i_freeze = 1'b0;
        tick();
        chk("conv_unfrz_state", 32'(o_state),     32'd2);
        chk("conv_unfrz_hold",  32'(o_converged), 32'd1);
        send(32'd2, 32'h100);
        chk("conv_clear", 32'(o_converged), 32'd0);

`ifdef LMS_CTRL_DIVERGENCE_EN
        send(32'd3, 32'h0050_0000);
        chk("div_lms_rst", 32'(o_lms_rst),   32'd1);
        chk("div_state",   32'(o_state),     32'd1);
        chk("div_flag",    32'(o_diverged),  32'd1);
        chk("div_err",     o_error,          32'd0);
        chk("div_cnt",     32'(o_train_cnt), 32'd0);
        chk("div_mu",      o_mu,             32'h200);
        tick();
        chk("div_pulse_end", 32'(o_lms_rst),  32'd0);
        chk("div_sticky",    32'(o_diverged), 32'd1);
`else
        send(32'd3, 32'h0050_0000);
        chk("nodiv_state", 32'(o_state),    32'd2);
        chk("nodiv_flag",  32'(o_diverged), 32'd0);
        chk("nodiv_err",   o_error,         32'h0050_0000);
`endif

        i_enable = 1'b0;
        tick();
        chk("dis_state",   32'(o_state),     32'd0);
        chk("dis_div",     32'(o_diverged),  32'd0);
        chk("dis_lms_rst", 32'(o_lms_rst),   32'd1);
        chk("dis_mu",      o_mu,             32'd0);
        chk("dis_x0",      o_x0,             32'd0);
        chk("dis_cnt",     32'(o_train_cnt), 32'd0);

        i_enable = 1'b1;
        tick();
        send(32'd7, 32'd5);
        chk("pre_rst_x0",  o_x0,    32'd7);
        chk("pre_rst_err", o_error, 32'd5);
        i_rst    = 1'b0;
        i_valid  = 1'b1;
        i_sample = 32'd8;
        i_error  = 32'd6;
        tick();
        i_valid  = 1'b0;
        chk("midrst_state",   32'(o_state),   32'd0);
        chk("midrst_x0",      o_x0,           32'd0);
        chk("midrst_err",     o_error,        32'd0);
        chk("midrst_lms_rst", 32'(o_lms_rst), 32'd1);
        chk("midrst_mu",      o_mu,           32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
